writeback_arbiter: RTL and testbench

Writeback stage that sits directly upstream of the register file and drives its write port (`rd_addr`, `rd_data`, `reg_write`). It merges single-cycle ALU results with results from long-latency units (loads, divider) through a small result FIFO. It also keeps a per-register busy scoreboard that the hazard logic uses to stall reads of registers with an outstanding long-latency result.

---
 rtl/writeback_arbiter.sv | 119 +++++++++++
 tb/tb_writeback_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued long-latency results onto
// the register-file write port and tracks outstanding long-latency destinations.
module writeback_arbiter #(
  parameter int unsigned Width     = 32,
  parameter int unsigned FifoDepth = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             alu_valid_i,
  input  logic [4:0]       alu_rd_i,
  input  logic [Width-1:0] alu_data_i,
  output logic             alu_stall_o,
  input  logic             ll_issue_i,
  input  logic [4:0]       ll_issue_rd_i,
  input  logic             ll_valid_i,
  input  logic [4:0]       ll_rd_i,
  input  logic [Width-1:0] ll_data_i,
  output logic             ll_ready_o,
  output logic [4:0]       rd_addr_o,
  output logic [Width-1:0] rd_data_o,
  output logic             reg_write_o,
  output logic [31:0]      busy_o,
  output logic             hazard_err_o
);

  localparam int unsigned AddrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned PtrW  = AddrW + 1;

  logic [4:0]       mem_rd_q   [FifoDepth];
  logic [Width-1:0] mem_data_q [FifoDepth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [Width-1:0] rd_data_q, rd_data_d;
  logic             reg_write_q, reg_write_d;
  logic [31:0]      busy_q, busy_d;
  logic             hazard_q, hazard_d;

  logic             full, empty, push, pop, alu_req;
  logic [4:0]       head_rd;
  logic [Width-1:0] head_data;
  logic [31:0]      set_mask, clr_mask;
  logic             issue_err, push_err;

  // Pointers carry a wrap bit: equal means empty, differing only in the wrap bit means full.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) &&
                     (wptr_q[AddrW] != rptr_q[AddrW]);
  assign head_rd   = mem_rd_q[rptr_q[AddrW-1:0]];
  assign head_data = mem_data_q[rptr_q[AddrW-1:0]];

  assign alu_req     = alu_valid_i && (alu_rd_i != 5'd0);
  assign ll_ready_o  = !reset_i && !full;
  assign push        = ll_valid_i && ll_ready_o;
  assign pop         = !reset_i && (full || (!alu_req && !empty));
  assign alu_stall_o = !reset_i && full && alu_req;

  assign set_mask  = (ll_issue_i && (ll_issue_rd_i != 5'd0)) ? (32'd1 << ll_issue_rd_i) : 32'd0;
  assign clr_mask  = pop ? (32'd1 << head_rd) : 32'd0;
  assign issue_err = ll_issue_i && (ll_issue_rd_i != 5'd0) && busy_q[ll_issue_rd_i] &&
                     !clr_mask[ll_issue_rd_i];
  assign push_err  = push && (ll_rd_i != 5'd0) && !busy_q[ll_rd_i];

  always_comb begin
    wptr_d      = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d      = pop ? rptr_q + PtrW'(1) : rptr_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    reg_write_d = 1'b0;
    if (pop) begin
      // Entries addressed to x0 are drained silently.
      if (head_rd != 5'd0) begin
        rd_addr_d   = head_rd;
        rd_data_d   = head_data;
        reg_write_d = 1'b1;
      end
    end else if (alu_req) begin
      rd_addr_d   = alu_rd_i;
      rd_data_d   = alu_data_i;
      reg_write_d = 1'b1;
    end
    // Set takes precedence over a same-cycle clear.
    busy_d      = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    hazard_d    = hazard_q | issue_err | push_err;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      reg_write_q <= 1'b0;
      busy_q      <= '0;
      hazard_q    <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      reg_write_q <= reg_write_d;
      busy_q      <= busy_d;
      hazard_q    <= hazard_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_rd_q[wptr_q[AddrW-1:0]]   <= ll_rd_i;
      mem_data_q[wptr_q[AddrW-1:0]] <= ll_data_i;
    end
  end

  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;
  assign reg_write_o  = reg_write_q;
  assign busy_o       = busy_q;
  assign hazard_err_o = hazard_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: ALU path, long-latency path, contention, scoreboard.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ll_issue, ll_valid;
  logic [4:0]  alu_rd, ll_issue_rd, ll_rd;
  logic [31:0] alu_data, ll_data;
  logic        alu_stall, ll_ready, reg_write, hazard_err;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, busy;

  int total = 0;
  int bad   = 0;

  writeback_arbiter #(.Width(32), .FifoDepth(2)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .alu_valid_i  (alu_valid),
    .alu_rd_i     (alu_rd),
    .alu_data_i   (alu_data),
    .alu_stall_o  (alu_stall),
    .ll_issue_i   (ll_issue),
    .ll_issue_rd_i(ll_issue_rd),
    .ll_valid_i   (ll_valid),
    .ll_rd_i      (ll_rd),
    .ll_data_i    (ll_data),
    .ll_ready_o   (ll_ready),
    .rd_addr_o    (rd_addr),
    .rd_data_o    (rd_data),
    .reg_write_o  (reg_write),
    .busy_o       (busy),
    .hazard_err_o (hazard_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ll_issue = 0; ll_issue_rd = 0; ll_valid = 0; ll_rd = 0; ll_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", reg_write); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy); end
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL rst_haz got=%0b exp=0", hazard_err); end
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", ll_ready); end
    total++; if (alu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", alu_stall); end
    reset = 0;
    #1;
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%0b exp=1", ll_ready); end
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hAA;
    #1;
    total++; if (alu_stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b exp=0", alu_stall); end
    tick();
    total++; if (reg_write !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hAA) begin
      bad++; $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/aa", reg_write, rd_addr, rd_data);
    end
    alu_rd = 0; alu_data = 32'h55;
    tick();
    total++; if (reg_write !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'hAA) begin
      bad++; $display("FAIL alu_x0 got=%0b/%0d/%h exp=0/5/aa", reg_write, rd_addr, rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_ll_path();
    ll_issue = 1; ll_issue_rd = 7;
    tick();
    ll_issue = 0;
    total++; if (busy !== 32'h80) begin bad++; $display("FAIL ll_busy_set got=%h exp=80", busy); end
    ll_valid = 1; ll_rd = 7; ll_data = 32'h1234;
    #1;
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL ll_ready got=%0b exp=1", ll_ready); end
    tick();
    ll_valid = 0;
    total++; if (reg_write !== 1'b0 || busy !== 32'h80) begin
      bad++; $display("FAIL ll_n1 got=%0b/%h exp=0/80", reg_write, busy);
    end
    tick();
    total++; if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h1234) begin
      bad++; $display("FAIL ll_write got=%0b/%0d/%h exp=1/7/1234", reg_write, rd_addr, rd_data);
    end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL ll_busy_clr got=%h exp=0", busy); end
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL ll_haz got=%0b exp=0", hazard_err); end
    idle_inputs();
  endtask

  task automatic test_contention();
    ll_issue = 1; ll_issue_rd = 10;
    tick();
    ll_issue_rd = 11;
    tick();
    ll_issue = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h100;
    ll_valid = 1; ll_rd = 10; ll_data = 32'hA0;
    tick();
    total++; if (rd_addr !== 5'd1 || rd_data !== 32'h100 || reg_write !== 1'b1) begin
      bad++; $display("FAIL cont_a got=%0d/%h exp=1/100", rd_addr, rd_data);
    end
    alu_data = 32'h101; ll_rd = 11; ll_data = 32'hB0;
    tick();
    total++; if (rd_data !== 32'h101 || reg_write !== 1'b1) begin
      bad++; $display("FAIL cont_b got=%h exp=101", rd_data);
    end
    ll_valid = 0; alu_data = 32'h102;
    #1;
    total++; if (ll_ready !== 1'b0 || alu_stall !== 1'b1) begin
      bad++; $display("FAIL cont_full got=ready%0b/stall%0b exp=0/1", ll_ready, alu_stall);
    end
    tick();
    total++; if (rd_addr !== 5'd10 || rd_data !== 32'hA0 || reg_write !== 1'b1) begin
      bad++; $display("FAIL cont_pop got=%0d/%h exp=10/a0", rd_addr, rd_data);
    end
    total++; if (busy !== 32'h800) begin bad++; $display("FAIL cont_busy got=%h exp=800", busy); end
    total++; if (ll_ready !== 1'b1 || alu_stall !== 1'b0) begin
      bad++; $display("FAIL cont_drain got=ready%0b/stall%0b exp=1/0", ll_ready, alu_stall);
    end
    tick();
    total++; if (rd_addr !== 5'd1 || rd_data !== 32'h102 || reg_write !== 1'b1) begin
      bad++; $display("FAIL cont_held got=%0d/%h exp=1/102", rd_addr, rd_data);
    end
    alu_valid = 0;
    tick();
    total++; if (rd_addr !== 5'd11 || rd_data !== 32'hB0 || reg_write !== 1'b1 || busy !== 32'h0) begin
      bad++; $display("FAIL cont_last got=%0d/%h/%h exp=11/b0/0", rd_addr, rd_data, busy);
    end
    tick();
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL cont_idle got=%0b exp=0", reg_write); end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    ll_issue = 1; ll_issue_rd = 9;
    tick();
    ll_issue = 0;
    ll_valid = 1; ll_rd = 9; ll_data = 32'h9;
    tick();
    ll_valid = 0;
    ll_issue = 1; ll_issue_rd = 9;
    tick();
    ll_issue = 0;
    total++; if (busy[9] !== 1'b1 || hazard_err !== 1'b0) begin
      bad++; $display("FAIL sim_set_wins got=busy%0b/haz%0b exp=1/0", busy[9], hazard_err);
    end
    total++; if (reg_write !== 1'b1 || rd_addr !== 5'd9) begin
      bad++; $display("FAIL sim_write got=%0b/%0d exp=1/9", reg_write, rd_addr);
    end
    ll_issue = 1; ll_issue_rd = 3;
    tick();
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL sim_first_issue got=%0b exp=0", hazard_err); end
    tick();
    ll_issue = 0;
    total++; if (hazard_err !== 1'b1) begin bad++; $display("FAIL sim_dup_issue got=%0b exp=1", hazard_err); end
    tick();
    tick();
    total++; if (hazard_err !== 1'b1) begin bad++; $display("FAIL sim_sticky got=%0b exp=1", hazard_err); end
    do_reset();
    total++; if (hazard_err !== 1'b0 || busy !== 32'h0) begin
      bad++; $display("FAIL sim_rst got=%0b/%h exp=0/0", hazard_err, busy);
    end
  endtask

  task automatic test_protocol();
    ll_valid = 1; ll_rd = 4; ll_data = 32'h44;
    tick();
    ll_valid = 0;
    total++; if (hazard_err !== 1'b1) begin bad++; $display("FAIL proto_push got=%0b exp=1", hazard_err); end
    tick();
    do_reset();
  endtask

  task automatic test_reset_mid();
    ll_issue = 1; ll_issue_rd = 7;
    tick();
    ll_issue = 0;
    alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
    ll_valid = 1; ll_rd = 7; ll_data = 32'h77;
    tick();
    idle_inputs();
    total++; if (busy !== 32'h80 || rd_addr !== 5'd2) begin
      bad++; $display("FAIL mid_pre got=%h/%0d exp=80/2", busy, rd_addr);
    end
    reset = 1;
    #1;
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%0b exp=0", ll_ready); end
    tick();
    total++; if (busy !== 32'h0 || reg_write !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'h0) begin
      bad++; $display("FAIL mid_rst got=%h/%0b/%0d/%h exp=0/0/0/0", busy, reg_write, rd_addr, rd_data);
    end
    reset = 0;
    #1;
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%0b exp=1", ll_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (reg_write !== 1'b0) begin
        bad++; $display("FAIL mid_no_write cyc=%0d got=%0b exp=0", i, reg_write);
      end
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_alu();
    test_ll_path();
    test_contention();
    test_simultaneous();
    test_protocol();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
